load_store_unit: RTL
====================

# load_store_unit

Word-memory initiator between the processor's data path and the 2-read/1-write, 32-bit, byte-addressed, little-endian memory model. Accepts byte, halfword and word load/store requests over a valid/ready handshake and drives one memory read port plus the write port. The memory only reads and writes whole aligned words, so sub-word stores use read-modify-write. Returns load data, sign- or zero-extended, over a valid/ready response channel.

## Interface
- ADDR_WIDTH, from simple_processor_pkg, byte address width
- DATA_WIDTH, from simple_processor_pkg (32), word width
- clk_i  in  1  single clock; all state changes on rising edge
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  request accepted when valid & ready
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed_i  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr_i  in  ADDR_WIDTH  byte address
- req_wdata_i  in  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed when valid & ready
- rsp_rdata_o  out  DATA_WIDTH  extended load data; 0 for stores and errors
- rsp_err_o  out  1  misaligned or illegal-size request
- mem_raddr_o  out  ADDR_WIDTH  word-aligned read address (to memory read port)
- mem_rdata_i  in  DATA_WIDTH  read data (memory returns it in the same cycle)
- mem_we_o  out  1  write enable
- mem_waddr_o  out  ADDR_WIDTH  word-aligned write address
- mem_wdata_o  out  DATA_WIDTH  full merged write word

## Operation
- FSM states: IDLE, READ, WRITE, RESP. `req_ready_o` = (state==IDLE) & !rst_i.
- On accept, latch we, size, signed, addr and wdata. Compute `aligned = {addr[ADDR_WIDTH-1:2],2'b00}` and `lane = addr[1:0]`.
- Error check at accept:
  - size 11 is illegal.
  - Halfword with addr[0]=1 is misaligned.
  - Word with lane != 0 is misaligned.
  - On error: IDLE→RESP, err=1, rdata=0, no memory access.
- Load: IDLE→READ→RESP.
  - In READ, mem_raddr_o = aligned; capture mem_rdata_i into a word register at the end of READ.
  - Extract byte at lane×8 or half at lane[1]×16, then extend per signed.
- Word store: IDLE→WRITE→RESP. In WRITE: mem_we_o=1, mem_waddr_o=aligned, mem_wdata_o=wdata.
- Sub-word store: IDLE→READ→WRITE→RESP.
  - In READ, capture the old word.
  - In WRITE, write the old word with only the target byte or half lanes replaced by wdata[7:0] or wdata[15:0].
- RESP:
  - rsp_valid_o=1; rsp_rdata_o and rsp_err_o stay stable until rsp_ready_i.
  - RESP→IDLE on rsp_ready_i.
  - No new request is accepted in the cycle the response retires.
- mem_raddr_o and mem_waddr_o always show the latched aligned address (0 after reset).
- mem_we_o is 1 only in WRITE and only when rst_i=0.

## Timing
- Reset values: state IDLE; rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, mem_we_o=0, mem_raddr_o=0, mem_waddr_o=0, mem_wdata_o=0. req_ready_o=0 while rst_i is high and 1 in the first cycle after release.
- Accept in cycle N. Then rsp_valid_o rises:
  - error: N+1
  - load: N+2
  - word store: N+2
  - sub-word store: N+3
- The store's write is committed by the memory at the clock edge that ends the WRITE cycle.
- Back-to-back throughput: one request per (latency + 1) cycles with rsp_ready_i held at 1.
- Reset asserted in any state:
  - Returns to IDLE at the next edge.
  - Any pending write is dropped, because mem_we_o is gated by rst_i in that same cycle.
  - Any pending response is discarded.
- req_valid_i outside IDLE is ignored; the requester must hold the request until accepted.
- rsp_valid_o stays high indefinitely while rsp_ready_i=0.

## Test plan
- Preload 0x100 = 0x8877_6655. Load byte, addr 0x103:
  - signed → 0xFFFF_FF88
  - unsigned → 0x0000_0088
  - rsp_valid_o at N+2
- Preload 0x100 = 0x8877_6655, store byte 0xAB at 0x101 → memory word 0x8877_AB55, mem_we_o high exactly one cycle (N+2), rsp_valid_o at N+3.
- Store half 0x1234 at 0x102, then load half signed 0x102 → 0x0000_1234. Then load word 0x100 → 0x1234_xxxx, where the low half is unchanged.
- Load word at 0x101; store half at 0x103; size 11 at 0x100 → each gives err=1 at N+1, rdata=0, mem_we_o never asserted.
- Hold rsp_ready_i=0 for 5 cycles after a load → rsp_valid_o and data stable, req_ready_o=0. Release → IDLE the next cycle.
- Assert rst_i in the WRITE cycle of a sub-word store → memory word unchanged, all outputs at reset values, req_ready_o=1 after release.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store initiator for a word-wide, byte-addressed, little-endian memory.
// Sub-word stores are done as read-modify-write; load data is sign- or zero-extended.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_signed_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] mem_raddr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_waddr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam int         NUM_LANES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                state_reg;
  logic                  we_reg;
  logic [1:0]            size_reg;
  logic                  signed_reg;
  logic [1:0]            lane_reg;
  logic [ADDR_WIDTH-1:0] aligned_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [DATA_WIDTH-1:0] mem_wdata_reg;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg;
  logic                  rsp_err_reg;
  logic                  rsp_valid_reg;

  logic                  req_err_next;
  logic [ADDR_WIDTH-1:0] req_aligned_next;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [DATA_WIDTH-1:0] load_ext_next;
  logic [DATA_WIDTH-1:0] merged_word_next;

  assign req_aligned_next = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign req_err_next = (req_size_i == 2'b11)
                      || ((req_size_i == SIZE_HALF) && req_addr_i[0])
                      || ((req_size_i == SIZE_WORD) && (req_addr_i[1:0] != 2'b00));

  // Load path: pick the addressed lane straight off the memory read port.
  assign load_byte = mem_rdata_i[{lane_reg, 3'b000} +: 8];
  assign load_half = mem_rdata_i[{lane_reg[1], 4'b0000} +: 16];

  always_comb begin
    load_ext_next = mem_rdata_i;
    case (size_reg)
      SIZE_BYTE: load_ext_next = {{(DATA_WIDTH-8){signed_reg & load_byte[7]}}, load_byte};
      SIZE_HALF: load_ext_next = {{(DATA_WIDTH-16){signed_reg & load_half[15]}}, load_half};
      default:   load_ext_next = mem_rdata_i;
    endcase
  end

  // Store path: each byte lane keeps the old word unless it is a target lane.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       lane_en;
      logic [7:0] new_byte;

      always_comb begin
        lane_en  = 1'b1;
        new_byte = wdata_reg[8*gi +: 8];
        case (size_reg)
          SIZE_BYTE: begin
            lane_en  = (lane_reg == LANE);
            new_byte = wdata_reg[7:0];
          end
          SIZE_HALF: begin
            lane_en  = (lane_reg[1] == LANE[1]);
            new_byte = wdata_reg[8*(gi%2) +: 8];
          end
          default: begin
            lane_en  = 1'b1;
            new_byte = wdata_reg[8*gi +: 8];
          end
        endcase
      end

      assign merged_word_next[8*gi +: 8] = lane_en ? new_byte : mem_rdata_i[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      we_reg        <= 1'b0;
      size_reg      <= 2'b00;
      signed_reg    <= 1'b0;
      lane_reg      <= 2'b00;
      aligned_reg   <= '0;
      wdata_reg     <= '0;
      mem_wdata_reg <= '0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
      rsp_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid_i) begin
            we_reg      <= req_we_i;
            size_reg    <= req_size_i;
            signed_reg  <= req_signed_i;
            lane_reg    <= req_addr_i[1:0];
            aligned_reg <= req_aligned_next;
            wdata_reg   <= req_wdata_i;
            if (req_err_next) begin
              rsp_err_reg   <= 1'b1;
              rsp_rdata_reg <= '0;
              rsp_valid_reg <= 1'b1;
              state_reg     <= RESP;
            end else if (req_we_i && (req_size_i == SIZE_WORD)) begin
              mem_wdata_reg <= req_wdata_i;
              state_reg     <= WRITE;
            end else begin
              state_reg <= READ;
            end
          end
        end
        READ: begin
          if (we_reg) begin
            mem_wdata_reg <= merged_word_next;
            state_reg     <= WRITE;
          end else begin
            rsp_rdata_reg <= load_ext_next;
            rsp_err_reg   <= 1'b0;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end
        end
        WRITE: begin
          rsp_rdata_reg <= '0;
          rsp_err_reg   <= 1'b0;
          rsp_valid_reg <= 1'b1;
          state_reg     <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Reset gates the handshake and the write strobe in the very cycle it is raised.
  assign req_ready_o = (state_reg == IDLE) && !rst_i;
  assign mem_we_o    = (state_reg == WRITE) && !rst_i;
  assign mem_raddr_o = aligned_reg;
  assign mem_waddr_o = aligned_reg;
  assign mem_wdata_o = mem_wdata_reg;
  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_rdata_o = rsp_rdata_reg;
  assign rsp_err_o   = rsp_err_reg;

endmodule
